alu_issue_stage: RTL
====================

// Module: alu_issue_stage
// PURPOSE
//  Operand issue stage directly upstream of the ALU. Holds the 32-entry register file, reads rs/rt for
//  a decoded instruction, selects an immediate or register B operand, forwards the ALU's
//  current result and the writeback value, and registers a/b/ctrl into one pipeline slot.
//  A valid/ready handshake feeds the ALU.
//  The ALU's combinational result returns on ex_result for back-to-back forwarding.
// PARAMETERS
//  WIDTH   32  datapath width (matches ALU width)
//  AW      5   register address width; 2**AW registers, register 0 hardwired to zero
// PORTS
//  clk         in   1      clock, all state updates on rising edge
//  rst         in   1      asynchronous reset, active-high
//  in_valid    in   1      decoded instruction present
//  in_ready    out  1      stage can accept an instruction this cycle
//  in_rs       in   AW     source register A
//  in_rt       in   AW     source register B
//  in_rd       in   AW     destination register
//  in_imm      in   16     immediate field
//  in_use_imm  in   1      1: B operand = extended immediate; 0: B = reg[rt]
//  in_sext     in   1      1: sign-extend imm; 0: zero-extend
//  in_ctrl     in   3      ALU op code, passed unchanged (000 and,001 or,010 xor,111 nor,100 add,110 sub,011 slt,other not)
//  in_wen      in   1      instruction writes rd
//  flush       in   1      discard held instruction
//  out_valid   out  1      out_* hold a valid ALU operation
//  out_ready   in   1      ALU/next stage consumes this cycle
//  out_a       out  WIDTH  ALU operand a
//  out_b       out  WIDTH  ALU operand b
//  out_ctrl    out  3      ALU ctrl
//  out_rd      out  AW     destination, carried forward
//  out_wen     out  1      write enable, carried forward
//  ex_result   in   WIDTH  ALU output computed from current out_a/out_b/out_ctrl
//  wb_en       in   1      register-file write enable
//  wb_addr     in   AW     write address
//  wb_data     in   WIDTH  write data
// BEHAVIOUR
//  - Reset (async): out_valid=0, out_a=out_b=0, out_ctrl=0, out_rd=0, out_wen=0, all registers=0.
//  - in_ready = !out_valid || out_ready (combinational); capture = in_valid && in_ready && !flush.
//  - One-entry slot, latency 1: operands captured on edge N appear on out_* after edge N.
//  - out_valid next: flush -> 0; else capture -> 1; else out_ready -> 0; else hold. out_* hold while stalled.
//  - Register file: write on edge when wb_en && wb_addr!=0; writes to 0 ignored; reads of 0 return 0.
//  - wb and flush are independent: a flush never blocks a wb write.
//  - Operand read for src s (rs or rt), priority high to low:
//     1. s==0 -> 0.
//     2. EX forward: out_valid && out_ready && out_wen && !flush && out_rd==s -> ex_result.
//     3. WB bypass: wb_en && wb_addr==s -> wb_data (same-cycle write visible).
//     4. reg[s].
//  - out_a = operand(rs). out_b = in_use_imm ? ext(in_imm) : operand(rt).
//  - ext: in_sext ? {{WIDTH-16{in_imm[15]}},in_imm} : {{WIDTH-16{1'b0}},in_imm}.
//  - Deeper hazards (e.g. load-use) are the decoder's job; this stage never stalls on data.
//  - flush with in_valid: the instruction is not captured and in_ready is still driven per formula.
//    Upstream must treat it as dropped.
//  - rs==rt with a forward applies to both; imm path ignores rt entirely.
// TESTING
//  - Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, out_*=0 immediately; reg[5] reads 0.
//  - WB bypass: wb_en=1,wb_addr=3,wb_data=0x0000_00AA with issue rs=3,rt=0,ctrl=100
//    -> next cycle out_a=0xAA, out_b=0.
//  - EX forward: held op rd=4,wen=1, ex_result=0x1234, out_ready=1, issue rs=4
//    -> out_a=0x1234 (wins over wb_en to addr 4 with 0x9999).
//  - Imm extend: imm=0xFFF0, use_imm=1: sext=1 -> out_b=0xFFFF_FFF0; sext=0 -> out_b=0x0000_FFF0.
//  - Stall/flush: out_ready=0 for 3 cycles -> in_ready=0, out_* stable.
//    Then flush=1 with in_valid -> out_valid=0, nothing captured.
//  - Reg 0: wb to addr 0 with 0xDEAD, issue rs=0 -> out_a=0; EX forward with out_rd=0 ignored.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Operand issue stage ahead of the ALU: register file, EX/WB forwarding, immediate
// extension and a single registered slot with a valid/ready handshake toward the ALU.
module alu_issue_stage #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [AW-1:0]    in_rs,
  input  logic [AW-1:0]    in_rt,
  input  logic [AW-1:0]    in_rd,
  input  logic [15:0]      in_imm,
  input  logic             in_use_imm,
  input  logic             in_sext,
  input  logic [2:0]       in_ctrl,
  input  logic             in_wen,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [2:0]       out_ctrl,
  output logic [AW-1:0]    out_rd,
  output logic             out_wen,
  input  logic [WIDTH-1:0] ex_result,
  input  logic             wb_en,
  input  logic [AW-1:0]    wb_addr,
  input  logic [WIDTH-1:0] wb_data
);
  localparam int NREG = 1 << AW;

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // out_* stay stable while out_valid && !out_ready; flush drops the held slot and
  // blocks capture of the incoming instruction in the same cycle.

  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_a_q, out_a_d;
  logic [WIDTH-1:0] out_b_q, out_b_d;
  logic [2:0]       out_ctrl_q, out_ctrl_d;
  logic [AW-1:0]    out_rd_q, out_rd_d;
  logic             out_wen_q, out_wen_d;

  logic             capture;
  logic             ex_fwd_en;
  logic [WIDTH-1:0] imm_ext;
  logic [WIDTH-1:0] op_rs;
  logic [WIDTH-1:0] op_rt;

  assign in_ready  = !out_valid_q || out_ready;
  assign capture   = in_valid && in_ready && !flush;
  // The held op only forwards when it actually retires into the ALU this cycle.
  assign ex_fwd_en = out_valid_q && out_ready && out_wen_q && !flush;
  assign imm_ext   = in_sext ? {{(WIDTH-16){in_imm[15]}}, in_imm}
                             : {{(WIDTH-16){1'b0}}, in_imm};

  // Sources are resolved lowest priority first so later assignments win.
  always_comb begin
    op_rs = regs_q[in_rs];
    if (wb_en && wb_addr == in_rs)         op_rs = wb_data;
    if (ex_fwd_en && out_rd_q == in_rs)    op_rs = ex_result;
    if (in_rs == '0)                       op_rs = '0;
  end

  always_comb begin
    op_rt = regs_q[in_rt];
    if (wb_en && wb_addr == in_rt)         op_rt = wb_data;
    if (ex_fwd_en && out_rd_q == in_rt)    op_rt = ex_result;
    if (in_rt == '0)                       op_rt = '0;
  end

  always_comb begin
    regs_d = regs_q;
    if (wb_en && wb_addr != '0) regs_d[wb_addr] = wb_data;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_a_d     = out_a_q;
    out_b_d     = out_b_q;
    out_ctrl_d  = out_ctrl_q;
    out_rd_d    = out_rd_q;
    out_wen_d   = out_wen_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
      out_a_d     = op_rs;
      out_b_d     = in_use_imm ? imm_ext : op_rt;
      out_ctrl_d  = in_ctrl;
      out_rd_d    = in_rd;
      out_wen_d   = in_wen;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      out_ctrl_q  <= '0;
      out_rd_q    <= '0;
      out_wen_q   <= 1'b0;
    end else begin
      regs_q      <= regs_d;
      out_valid_q <= out_valid_d;
      out_a_q     <= out_a_d;
      out_b_q     <= out_b_d;
      out_ctrl_q  <= out_ctrl_d;
      out_rd_q    <= out_rd_d;
      out_wen_q   <= out_wen_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign out_ctrl  = out_ctrl_q;
  assign out_rd    = out_rd_q;
  assign out_wen   = out_wen_q;

endmodule
